// File: rtl/anc_pkg.sv
// Shared definitions for the ANC LMS sample-rate sequencer.
package anc_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_OUT_W   = 16;
    localparam int DEF_FRAC    = 15;
    localparam int DEF_TIMEOUT = 140;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        FIRE,
        WAIT,
        OUT
    } anc_state_t;

endpackage

// File: rtl/anc_sat.sv
// Signed saturating narrower: clamps IN_W-bit value into OUT_W bits.
module anc_sat #(
    parameter int IN_W  = 33,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    // In range only when every bit above the output sign bit matches it.
    logic [IN_W-OUT_W:0] top;

    assign top = din[IN_W-1:OUT_W-1];

    always_comb begin
        if ((&top) || (~|top)) begin
            dout = din[OUT_W-1:0];
        end else if (din[IN_W-1]) begin
            dout = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            dout = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/anc_lms_ctrl.sv
// Pairs ref/err samples, computes mu*e, runs the FIR engine and
// emits the negated, saturated anti-noise sample.
module anc_lms_ctrl
    import anc_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int FRAC    = DEF_FRAC,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ref_in,
    input  logic              ref_valid,
    input  logic [DATA_W-1:0] err_in,
    input  logic              err_valid,
    input  logic [15:0]       mu,
    input  logic              clr_flags,
    output logic [DATA_W-1:0] feedforward_out,
    output logic [DATA_W-1:0] weight_adjust,
    output logic              go,
    input  logic              fir_done,
    input  logic [DATA_W-1:0] fir_out_sample,
    output logic [OUT_W-1:0]  anc_out,
    output logic              anc_valid,
    output logic              busy,
    output logic              overrun,
    output logic              fault
);

    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam int PROD_W = DATA_W + 17;

    anc_state_t state, state_nx;

    logic [DATA_W-1:0] ref_hold, err_hold;
    logic [DATA_W-1:0] pend_ref, pend_err;
    logic [DATA_W-1:0] cur_ref, cur_err;
    logic              have_ref, have_err, pend_full;
    logic [CNT_W-1:0]  wd_cnt;

    logic pair_ready, pop, slot_free, drop;
    logic ref_rep, err_rep, done_hit, wd_expired;

    logic signed [PROD_W-1:0] prod, prod_sh;
    logic signed [DATA_W-1:0] wa_sat;
    logic signed [DATA_W:0]   neg;
    logic signed [OUT_W-1:0]  out_sat;

    assign pair_ready = have_ref & have_err;
    assign pop        = (state == IDLE) & pend_full;
    assign slot_free  = ~pend_full | pop;
    assign drop       = pair_ready & ~slot_free;
    // A channel being consumed this cycle is free for a fresh strobe.
    assign ref_rep    = ref_valid & have_ref & ~pair_ready;
    assign err_rep    = err_valid & have_err & ~pair_ready;
    assign done_hit   = (state == WAIT) & fir_done;
    assign wd_expired = (state == WAIT) & ~fir_done
                      & (wd_cnt == CNT_W'(TIMEOUT - 1));

    assign prod    = $signed(cur_err) * $signed({1'b0, mu});
    assign prod_sh = prod >>> FRAC;
    assign neg     = -$signed({fir_out_sample[DATA_W-1], fir_out_sample});

    anc_sat #(
        .IN_W  (PROD_W),
        .OUT_W (DATA_W)
    ) u_sat_wa (
        .din  (prod_sh),
        .dout (wa_sat)
    );

    anc_sat #(
        .IN_W  (DATA_W + 1),
        .OUT_W (OUT_W)
    ) u_sat_out (
        .din  (neg),
        .dout (out_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        go        = 1'b0;
        anc_valid = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE: if (pend_full) state_nx = CALC;
            CALC: state_nx = FIRE;
            FIRE: begin
                go       = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                if (fir_done) begin
                    state_nx = OUT;
                end else if (wd_expired) begin
                    state_nx = IDLE;
                end
            end
            OUT: begin
                anc_valid = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            have_ref  <= 1'b0;
            have_err  <= 1'b0;
            ref_hold  <= '0;
            err_hold  <= '0;
            pend_full <= 1'b0;
            pend_ref  <= '0;
            pend_err  <= '0;
        end else begin
            if (ref_valid) begin
                ref_hold <= ref_in;
                have_ref <= 1'b1;
            end else if (pair_ready) begin
                have_ref <= 1'b0;
            end
            if (err_valid) begin
                err_hold <= err_in;
                have_err <= 1'b1;
            end else if (pair_ready) begin
                have_err <= 1'b0;
            end
            if (pair_ready && slot_free) begin
                pend_ref  <= ref_hold;
                pend_err  <= err_hold;
                pend_full <= 1'b1;
            end else if (pop) begin
                pend_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_ref         <= '0;
            cur_err         <= '0;
            feedforward_out <= '0;
            weight_adjust   <= '0;
            anc_out         <= '0;
            wd_cnt          <= '0;
        end else begin
            if (pop) begin
                cur_ref <= pend_ref;
                cur_err <= pend_err;
            end
            if (state == CALC) begin
                feedforward_out <= cur_ref;
                weight_adjust   <= wa_sat;
            end
            if (done_hit) begin
                anc_out <= out_sat;
            end
            if (state == FIRE) begin
                wd_cnt <= '0;
            end else if (state == WAIT) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end

    // Set conditions take priority over clr_flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
            fault   <= 1'b0;
        end else begin
            if (ref_rep || err_rep || drop) begin
                overrun <= 1'b1;
            end else if (clr_flags) begin
                overrun <= 1'b0;
            end
            if (wd_expired) begin
                fault <= 1'b1;
            end else if (clr_flags) begin
                fault <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_anc_lms_ctrl.sv
// Directed scoreboard bench for anc_lms_ctrl.
`timescale 1ns/1ps
module tb_anc_lms_ctrl;

    localparam int TO = 140;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ref_in, err_in;
    logic        ref_valid, err_valid;
    logic [15:0] mu;
    logic        clr_flags;
    logic [31:0] feedforward_out, weight_adjust;
    logic        go;
    logic        fir_done;
    logic [31:0] fir_out_sample;
    logic [15:0] anc_out;
    logic        anc_valid, busy, overrun, fault;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] q_go[$];
    logic [15:0] q_anc[$];
    logic [63:0] e_go;
    logic [15:0] e_anc;

    always #5 clk = ~clk;

    anc_lms_ctrl #(
        .DATA_W  (32),
        .OUT_W   (16),
        .FRAC    (15),
        .TIMEOUT (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ref_in          (ref_in),
        .ref_valid       (ref_valid),
        .err_in          (err_in),
        .err_valid       (err_valid),
        .mu              (mu),
        .clr_flags       (clr_flags),
        .feedforward_out (feedforward_out),
        .weight_adjust   (weight_adjust),
        .go              (go),
        .fir_done        (fir_done),
        .fir_out_sample  (fir_out_sample),
        .anc_out         (anc_out),
        .anc_valid       (anc_valid),
        .busy            (busy),
        .overrun         (overrun),
        .fault           (fault)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] m_wa(input logic [31:0] e,
                                         input logic [15:0] m);
        longint p;
        p = longint'($signed(e)) * longint'({1'b0, m});
        p = p >>> 15;
        if (p > 64'sd2147483647) p = 64'sd2147483647;
        if (p < -64'sd2147483648) p = -64'sd2147483648;
        return p[31:0];
    endfunction

    function automatic logic [15:0] m_anc(input logic [31:0] s);
        longint n;
        n = -longint'($signed(s));
        if (n > 64'sd32767) n = 64'sd32767;
        if (n < -64'sd32768) n = -64'sd32768;
        return n[15:0];
    endfunction

    // Scoreboard: each go / anc_valid consumes one queued expectation.
    always @(negedge clk) begin
        if (go) begin
            if (q_go.size() == 0) begin
                chk("unexpected_go", 64'd1, 64'd0);
            end else begin
                e_go = q_go.pop_front();
                chk("go_ff_wa", {feedforward_out, weight_adjust}, e_go);
            end
        end
        if (anc_valid) begin
            if (q_anc.size() == 0) begin
                chk("unexpected_anc", 64'd1, 64'd0);
            end else begin
                e_anc = q_anc.pop_front();
                chk("anc_out", {48'd0, anc_out}, {48'd0, e_anc});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_pair(input logic [31:0] r, input logic [31:0] e);
        ref_in    = r;
        err_in    = e;
        ref_valid = 1'b1;
        err_valid = 1'b1;
        q_go.push_back({r, m_wa(e, mu)});
        tick();
        ref_valid = 1'b0;
        err_valid = 1'b0;
    endtask

    task automatic wait_go();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (go) begin
                seen = 1'b1;
                break;
            end
        end
        chk("go_seen", {63'd0, seen}, 64'd1);
    endtask

    task automatic finish_run(input logic [31:0] fos);
        q_anc.push_back(m_anc(fos));
        fir_out_sample = fos;
        fir_done       = 1'b1;
        tick();
        fir_done = 1'b0;
        chk("anc_valid_k1", {63'd0, anc_valid}, 64'd1);
        tick();
    endtask

    initial begin
        rst            = 1'b1;
        ref_in         = '0;
        err_in         = '0;
        ref_valid      = 1'b0;
        err_valid      = 1'b0;
        mu             = 16'h4000;
        clr_flags      = 1'b0;
        fir_done       = 1'b0;
        fir_out_sample = '0;
        tick();
        tick();
        chk("rst_ff", {32'd0, feedforward_out}, 64'd0);
        chk("rst_wa", {32'd0, weight_adjust}, 64'd0);
        chk("rst_go", {63'd0, go}, 64'd0);
        chk("rst_anc", {48'd0, anc_out}, 64'd0);
        chk("rst_anc_valid", {63'd0, anc_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_overrun", {63'd0, overrun}, 64'd0);
        chk("rst_fault", {63'd0, fault}, 64'd0);
        rst = 1'b0;
        tick();

        // Basic run with exact pair-to-go latency.
        strobe_pair(32'h100, 32'd1000);
        chk("go_n1", {63'd0, go}, 64'd0);
        tick();
        chk("go_n2", {63'd0, go}, 64'd0);
        tick();
        chk("go_n3", {63'd0, go}, 64'd0);
        chk("busy_calc", {63'd0, busy}, 64'd1);
        tick();
        chk("go_n4", {63'd0, go}, 64'd1);
        chk("wa_500", {32'd0, weight_adjust}, 64'd500);
        chk("ff_100", {32'd0, feedforward_out}, 64'h100);
        tick();
        chk("go_once", {63'd0, go}, 64'd0);
        finish_run(32'h1234);
        chk("anc_edcc", {48'd0, anc_out}, 64'hEDCC);
        chk("anc_valid_drop", {63'd0, anc_valid}, 64'd0);

        // Saturation of weight_adjust and anc_out.
        mu = 16'hFFFF;
        strobe_pair(32'h5, 32'h7FFFFFFF);
        wait_go();
        chk("wa_sat_pos", {32'd0, weight_adjust}, 64'h7FFFFFFF);
        tick();
        finish_run(32'd40000);
        chk("anc_neg_sat", {48'd0, anc_out}, 64'h8000);
        mu = 16'h2000;
        strobe_pair(32'h6, 32'hFFFF0000);
        wait_go();
        tick();
        finish_run(-32'sd40000);
        chk("anc_pos_sat", {48'd0, anc_out}, 64'h7FFF);
        strobe_pair(32'h7, 32'h80000000);
        wait_go();
        tick();
        finish_run(32'h80000000);
        chk("anc_min_neg", {48'd0, anc_out}, 64'h7FFF);

        // Repeat ref strobe: overrun, second value wins.
        mu        = 16'h4000;
        ref_in    = 32'hAAAA;
        ref_valid = 1'b1;
        tick();
        ref_in = 32'hBBBB;
        tick();
        ref_valid = 1'b0;
        chk("overrun_rep", {63'd0, overrun}, 64'd1);
        err_in    = 32'd64;
        err_valid = 1'b1;
        q_go.push_back({32'hBBBB, m_wa(32'd64, mu)});
        tick();
        err_valid = 1'b0;
        wait_go();
        tick();
        finish_run(32'd77);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("overrun_clr", {63'd0, overrun}, 64'd0);

        // Three pairs during a stalled WAIT: 2 pending, 3 dropped.
        strobe_pair(32'h11, 32'd100);
        wait_go();
        tick();
        strobe_pair(32'h22, 32'd200);
        tick();
        tick();
        ref_in    = 32'h33;
        err_in    = 32'd300;
        ref_valid = 1'b1;
        err_valid = 1'b1;
        tick();
        ref_valid = 1'b0;
        err_valid = 1'b0;
        tick();
        chk("overrun_drop", {63'd0, overrun}, 64'd1);
        finish_run(32'd5);
        chk("idle_one_cycle", {63'd0, busy}, 64'd0);
        tick();
        chk("calc_no_bubble", {63'd0, busy}, 64'd1);
        tick();
        chk("go_pair2", {63'd0, go}, 64'd1);
        tick();
        finish_run(32'd6);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;

        // Watchdog: no fir_done.
        strobe_pair(32'h44, 32'd400);
        wait_go();
        repeat (TO) tick();
        chk("fault_early", {63'd0, fault}, 64'd0);
        chk("busy_wait", {63'd0, busy}, 64'd1);
        tick();
        chk("fault_set", {63'd0, fault}, 64'd1);
        chk("busy_after_fault", {63'd0, busy}, 64'd0);
        strobe_pair(32'h55, 32'd500);
        wait_go();
        tick();
        finish_run(32'd9);
        chk("fault_sticky", {63'd0, fault}, 64'd1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("fault_clr", {63'd0, fault}, 64'd0);

        // Reset during WAIT with overrun set.
        ref_in    = 32'h66;
        ref_valid = 1'b1;
        tick();
        tick();
        ref_valid = 1'b0;
        err_in    = 32'd600;
        err_valid = 1'b1;
        q_go.push_back({32'h66, m_wa(32'd600, mu)});
        tick();
        err_valid = 1'b0;
        wait_go();
        tick();
        rst = 1'b1;
        tick();
        chk("mid_ff", {32'd0, feedforward_out}, 64'd0);
        chk("mid_wa", {32'd0, weight_adjust}, 64'd0);
        chk("mid_go", {63'd0, go}, 64'd0);
        chk("mid_anc", {48'd0, anc_out}, 64'd0);
        chk("mid_anc_valid", {63'd0, anc_valid}, 64'd0);
        chk("mid_busy", {63'd0, busy}, 64'd0);
        chk("mid_overrun", {63'd0, overrun}, 64'd0);
        chk("mid_fault", {63'd0, fault}, 64'd0);
        rst            = 1'b0;
        fir_out_sample = 32'd123;
        fir_done       = 1'b1;
        tick();
        fir_done = 1'b0;
        chk("late_done_ignored", {63'd0, anc_valid}, 64'd0);
        repeat (10) tick();
        chk("q_go_empty", 64'(q_go.size()), 64'd0);
        chk("q_anc_empty", 64'(q_anc.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
